// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - clock-manager reset and lock-qualification sequencer
module reset_sequencer #(
    parameter int DCM_RESET_CYCLES    = 4,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       dcm_reset,
    output logic       system_reset,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count
);

    // One counter serves every timed state, so it is sized for the longest interval.
    localparam int MAX_AB  = (DCM_RESET_CYCLES > LOCK_STABLE_CYCLES) ? DCM_RESET_CYCLES
                                                                     : LOCK_STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DCM_LAST     = CNT_W'(DCM_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_DCM,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             locked_meta_q;
    logic             locked_sync;
    logic             dcm_reset_q;
    logic             system_reset_q;
    logic             ready_q;
    logic             fault_q;

    // Two-flop synchronizer: locked comes from the clock manager with no phase relation.
    always_ff @(posedge clock) begin
        if (reset) begin
            locked_meta_q <= 1'b0;
            locked_sync   <= 1'b0;
        end else begin
            locked_meta_q <= locked;
            locked_sync   <= locked_meta_q;
        end
    end

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            RESET_DCM: begin
                // Lock reports during the reset pulse are meaningless and ignored.
                if (cnt_q == DCM_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 2'd1;
                        state_d = RESET_DCM;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABILIZE: begin
                // Any dropout restarts qualification without spending a retry.
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Lock loss after release is a fresh sequence, so the retry budget refills.
                if (!locked_sync) begin
                    state_d = RESET_DCM;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_DCM;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
    end

    // State register plus outputs registered from the next state so they track the state exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RESET_DCM;
            cnt_q          <= '0;
            retry_q        <= '0;
            dcm_reset_q    <= 1'b1;
            system_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            dcm_reset_q    <= (state_d == RESET_DCM);
            system_reset_q <= (state_d != RUN);
            ready_q        <= (state_d == RUN);
            fault_q        <= (state_d == FAULT);
        end
    end

    assign dcm_reset    = dcm_reset_q;
    assign system_reset = system_reset_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int DCM = 4;
    localparam int STB = 16;
    localparam int TO  = 1024;
    localparam int MR  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       dcm_reset;
    logic       system_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;

    always #5 clock = ~clock;

    reset_sequencer #(
        .DCM_RESET_CYCLES   (DCM),
        .LOCK_STABLE_CYCLES (STB),
        .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES        (MR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .dcm_reset   (dcm_reset),
        .system_reset(system_reset),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pulse cycles left, time spent waiting, stable run length.
    int m_dcm_left;
    int m_wait;
    int m_stable;
    bit m_run;
    bit m_fault;
    int m_retry;
    bit m_s1;
    bit m_s2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic lk);
        bit ls;
        if (rst) begin
            m_dcm_left = DCM;
            m_wait     = -1;
            m_stable   = -1;
            m_run      = 1'b0;
            m_fault    = 1'b0;
            m_retry    = 0;
            m_s1       = 1'b0;
            m_s2       = 1'b0;
        end else begin
            ls = m_s2;
            if (m_dcm_left > 0) begin
                m_dcm_left--;
                if (m_dcm_left == 0) m_wait = 0;
            end else if (m_wait >= 0) begin
                if (ls) begin
                    m_wait   = -1;
                    m_stable = 0;
                end else if (m_wait == TO - 1) begin
                    m_wait = -1;
                    if (m_retry < MR) begin
                        m_retry++;
                        m_dcm_left = DCM;
                    end else begin
                        m_fault = 1'b1;
                    end
                end else begin
                    m_wait++;
                end
            end else if (m_stable >= 0) begin
                if (!ls) begin
                    m_stable = -1;
                    m_wait   = 0;
                end else begin
                    m_stable++;
                    if (m_stable == STB) begin
                        m_stable = -1;
                        m_run    = 1'b1;
                    end
                end
            end else if (m_run) begin
                if (!ls) begin
                    m_run      = 1'b0;
                    m_retry    = 0;
                    m_dcm_left = DCM;
                end
            end
            m_s2 = m_s1;
            m_s1 = lk;
        end
    endtask

    task automatic step(input logic rst, input logic lk);
        reset  = rst;
        locked = lk;
        @(posedge clock);
        model_edge(rst, lk);
        #1;
        chk("dcm_reset",    16'(dcm_reset),    16'(m_dcm_left > 0));
        chk("system_reset", 16'(system_reset), 16'(!m_run));
        chk("ready",        16'(ready),        16'(m_run));
        chk("fault",        16'(fault),        16'(m_fault));
        chk("retry_count",  16'(retry_count),  16'(m_retry));
    endtask

    // Applies reset, releases it, and returns how many edges dcm_reset stayed high afterwards.
    task automatic reset_and_pulse(input logic lk, output int n);
        step(1'b1, lk);
        step(1'b1, lk);
        n = 0;
        while (dcm_reset && n < 50) begin
            step(1'b0, lk);
            n++;
        end
    endtask

    initial begin
        int n;
        int k;
        bit lk;
        reset  = 1'b1;
        locked = 1'b0;
        m_dcm_left = DCM; m_wait = -1; m_stable = -1; m_run = 0; m_fault = 0;
        m_retry = 0; m_s1 = 0; m_s2 = 0;

        // Nominal bring-up: lock 10 cycles after the pulse, release 18 edges after first sample.
        reset_and_pulse(1'b0, n);
        chk("pulse_after_reset", 16'(n), 16'(DCM));
        repeat (9) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        k = 0;
        while (!ready && k < 100) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("nominal_release_edges", 16'(k), 16'd18);
        chk("nominal_retry", 16'(retry_count), 16'd0);
        repeat (20) step(1'b0, 1'b1);

        // Lock loss in RUN: one low sample takes system_reset high two edges later.
        step(1'b0, 1'b0);
        k = 0;
        while (!system_reset && k < 10) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("loss_to_sysreset_edges", 16'(k), 16'd2);
        k = 0;
        while (!ready && k < 100) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("relock_ready", 16'(ready), 16'd1);

        // Glitch during stabilization restarts qualification from the second rise.
        reset_and_pulse(1'b0, n);
        chk("pulse_before_glitch", 16'(n), 16'(DCM));
        repeat (5) step(1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        k = 0;
        while (!ready && k < 100) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("glitch_release_edges", 16'(k), 16'd18);

        // Reset mid-stabilize, with locked held high through the pulse (ignored there).
        step(1'b1, 1'b1);
        n = 0;
        while (dcm_reset && n < 50) begin
            step(1'b0, 1'b1);
            n++;
        end
        step(1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midstab_reset_dcm", 16'(dcm_reset), 16'd1);
        n = 0;
        while (dcm_reset && n < 50) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("pulse_after_midstab", 16'(n), 16'(DCM));
        repeat (30) step(1'b0, 1'b1);
        chk("midstab_then_ready", 16'(ready), 16'd1);

        // Timeout retries exhaust the budget and land in fault.
        reset_and_pulse(1'b0, n);
        k = n;
        while (!fault && k < 5000) begin
            step(1'b0, 1'b0);
            k++;
        end
        chk("fault_edges", 16'(k), 16'((MR + 1) * (DCM + TO)));
        repeat (50) step(1'b0, 1'b0);
        chk("fault_held", 16'({fault, dcm_reset, system_reset}), 16'b101);

        // Reset out of fault, then lock during the second wait window.
        step(1'b1, 1'b0);
        chk("fault_reset_clears", 16'({fault, dcm_reset}), 16'b01);
        n = 0;
        while (dcm_reset && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("pulse_after_fault", 16'(n), 16'(DCM));
        k = 0;
        while (!(retry_count == 2'd1 && !dcm_reset) && k < 2000) begin
            step(1'b0, 1'b0);
            k++;
        end
        repeat (20) step(1'b0, 1'b0);
        k = 0;
        while (!ready && k < 100) begin
            step(1'b0, 1'b1);
            k++;
        end
        repeat (30) step(1'b0, 1'b1);
        chk("recovered_retry", 16'({ready, retry_count}), 16'b101);

        // Randomized lock activity with occasional resets, tracked by the model.
        lk = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) lk = ~lk;
            step($urandom_range(0, 599) == 0, lk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
